// File: rtl/alu_pkg.sv
// Shared types for the ALU flags unit: opcode map, multiplier FSM states
// and the architectural datapath width.
package alu_pkg;

  localparam int ALU_W = 8;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_ADDC = 4'd1,
    OP_SUB  = 4'd2,
    OP_SUBC = 4'd3,
    OP_CMP  = 4'd4,
    OP_AND  = 4'd5,
    OP_OR   = 4'd6,
    OP_EXOR = 4'd7,
    OP_TEST = 4'd8,
    OP_LSL  = 4'd9,
    OP_LSR  = 4'd10,
    OP_ROL  = 4'd11,
    OP_ROR  = 4'd12,
    OP_ASR  = 4'd13,
    OP_MOV  = 4'd14,
    OP_MUL  = 4'd15
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/alu_flags_unit_flag_reg.sv
// Single architectural flag bit with its interrupt shadow copy.
// Priority: rst, restore-from-shadow, clear, set, load, hold.
// The shadow captures the registered flag, so a simultaneous shadow load
// and restore swaps the two bits.
module flag_reg (
  input  logic clk,
  input  logic rst,
  input  logic ld_sel,
  input  logic shad_ld,
  input  logic clr,
  input  logic set,
  input  logic ld,
  input  logic d,
  output logic q
);

  logic shadow;

  // Flag and shadow update, both cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      q      <= 1'b0;
      shadow <= 1'b0;
    end else begin
      if (ld_sel)      q <= shadow;
      else if (clr)    q <= 1'b0;
      else if (set)    q <= 1'b1;
      else if (ld)     q <= d;
      if (shad_ld)     shadow <= q;
    end
  end

endmodule

// File: rtl/alu_flags_unit.sv
// 8-bit ALU stage with architectural C/Z flags and their interrupt shadows.
// RESULT is combinational; flags update on the next rising CLK.
// Optional macro ALU_MUL_EN turns opcode 15 into an 8-cycle shift-add
// unsigned multiply; without it opcode 15 yields zero and BUSY is tied low.
module alu_flags_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_W
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [3:0]       ALU_SEL,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             FLG_C_LD,
  input  logic             FLG_Z_LD,
  input  logic             FLG_C_SET,
  input  logic             FLG_C_CLR,
  input  logic             FLG_SHAD_LD,
  input  logic             FLG_LD_SEL,
  input  logic             START,
  output logic [WIDTH-1:0] RESULT,
  output logic             C_FLAG,
  output logic             Z_FLAG,
  output logic             BUSY
);

  alu_op_t    op;
  logic [7:0] res;
  logic [7:0] z_src;
  logic [8:0] arith;
  logic       c_next;
  logic       z_next;

  // Multiplier interface into the flag path.
  logic       mul_done;
  logic       mul_c;
  logic       mul_z;
  logic [7:0] mul_lo;

  assign op = alu_op_t'(ALU_SEL);

`ifdef ALU_MUL_EN
  mul_state_t state;
  mul_state_t state_nxt;
  logic [15:0] mcand;
  logic [15:0] prod;
  logic [7:0]  mplier;
  logic [2:0]  cnt;
  logic        prod_vld;
  logic        start_go;

  assign start_go = (state == IDLE) && START && (op == OP_MUL);

  // Multiplier state register.
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: idle until started, eight partial products, one done cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_go) state_nxt = RUN;
      RUN:     if (cnt == 3'd7) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Shift-add datapath: one multiplier bit consumed per RUN cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      prod     <= 16'h0000;
      cnt      <= 3'd0;
      prod_vld <= 1'b0;
    end else if (start_go) begin
      mcand    <= {8'h00, A};
      mplier   <= B;
      prod     <= 16'h0000;
      cnt      <= 3'd0;
      prod_vld <= 1'b0;
    end else if (state == RUN) begin
      if (mplier[0]) prod <= prod + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 3'd1;
    end else if (state == DONE) begin
      prod_vld <= 1'b1;
    end
  end

  assign mul_done = (state == DONE);
  assign mul_c    = (prod[15:8] != 8'h00);
  assign mul_z    = (prod[7:0] == 8'h00);
  assign mul_lo   = ((state == DONE) || ((state == IDLE) && prod_vld)) ? prod[7:0] : 8'h00;
  assign BUSY     = (state == RUN);
`else
  logic unused_start;

  assign unused_start = START;
  assign mul_done     = 1'b0;
  assign mul_c        = 1'b0;
  assign mul_z        = 1'b0;
  assign mul_lo       = 8'h00;
  assign BUSY         = 1'b0;
`endif

  // Opcode decode: result, carry and zero candidates for the flag registers.
  always_comb begin
    arith  = 9'h000;
    res    = A;
    c_next = 1'b0;
    case (op)
      OP_ADD:  begin arith = {1'b0, A} + {1'b0, B};                 res = arith[7:0]; c_next = arith[8]; end
      OP_ADDC: begin arith = {1'b0, A} + {1'b0, B} + {8'h00, C_FLAG}; res = arith[7:0]; c_next = arith[8]; end
      OP_SUB:  begin arith = {1'b0, A} - {1'b0, B};                 res = arith[7:0]; c_next = arith[8]; end
      OP_SUBC: begin arith = {1'b0, A} - {1'b0, B} - {8'h00, C_FLAG}; res = arith[7:0]; c_next = arith[8]; end
      OP_CMP:  begin arith = {1'b0, A} - {1'b0, B};                 res = A;          c_next = arith[8]; end
      OP_AND:  res = A & B;
      OP_OR:   res = A | B;
      OP_EXOR: res = A ^ B;
      OP_TEST: res = A;
      OP_LSL:  begin res = {A[6:0], C_FLAG}; c_next = A[7]; end
      OP_LSR:  begin res = {C_FLAG, A[7:1]}; c_next = A[0]; end
      OP_ROL:  begin res = {A[6:0], A[7]};   c_next = A[7]; end
      OP_ROR:  begin res = {A[0], A[7:1]};   c_next = A[0]; end
      OP_ASR:  begin res = {A[7], A[7:1]};   c_next = A[0]; end
      OP_MOV:  begin res = B;                c_next = C_FLAG; end
      OP_MUL:  res = mul_lo;
      default: res = 8'h00;
    endcase
    // CMP and TEST leave the operand untouched but flag the hidden result.
    z_src = res;
    if (op == OP_CMP)       z_src = arith[7:0];
    else if (op == OP_TEST) z_src = A & B;
    z_next = (z_src == 8'h00);
  end

  assign RESULT = res;

  flag_reg u_c_flag (
    .clk     (CLK),
    .rst     (RST),
    .ld_sel  (FLG_LD_SEL),
    .shad_ld (FLG_SHAD_LD),
    .clr     (FLG_C_CLR & ~mul_done),
    .set     (FLG_C_SET & ~mul_done),
    .ld      (FLG_C_LD | mul_done),
    .d       (mul_done ? mul_c : c_next),
    .q       (C_FLAG)
  );

  flag_reg u_z_flag (
    .clk     (CLK),
    .rst     (RST),
    .ld_sel  (FLG_LD_SEL),
    .shad_ld (FLG_SHAD_LD),
    .clr     (1'b0),
    .set     (1'b0),
    .ld      (FLG_Z_LD | mul_done),
    .d       (mul_done ? mul_z : z_next),
    .q       (Z_FLAG)
  );

endmodule

// File: tb/tb_alu_flags_unit.sv
// Directed self-checking bench for alu_flags_unit.
// Multiply scenario follows ALU_MUL_EN; otherwise the reserved opcode is checked.
module tb_alu_flags_unit;

  logic       CLK;
  logic       RST;
  logic [3:0] ALU_SEL;
  logic [7:0] A;
  logic [7:0] B;
  logic       FLG_C_LD, FLG_Z_LD, FLG_C_SET, FLG_C_CLR, FLG_SHAD_LD, FLG_LD_SEL;
  logic       START;
  logic [7:0] RESULT;
  logic       C_FLAG, Z_FLAG, BUSY;

  int n_checks = 0;
  int n_fail   = 0;

  alu_flags_unit #(.WIDTH(8)) dut (
    .CLK(CLK), .RST(RST), .ALU_SEL(ALU_SEL), .A(A), .B(B),
    .FLG_C_LD(FLG_C_LD), .FLG_Z_LD(FLG_Z_LD), .FLG_C_SET(FLG_C_SET),
    .FLG_C_CLR(FLG_C_CLR), .FLG_SHAD_LD(FLG_SHAD_LD), .FLG_LD_SEL(FLG_LD_SEL),
    .START(START), .RESULT(RESULT), .C_FLAG(C_FLAG), .Z_FLAG(Z_FLAG), .BUSY(BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic idle_ctl();
    RST = 1'b0; FLG_C_LD = 1'b0; FLG_Z_LD = 1'b0; FLG_C_SET = 1'b0;
    FLG_C_CLR = 1'b0; FLG_SHAD_LD = 1'b0; FLG_LD_SEL = 1'b0; START = 1'b0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    idle_ctl(); ALU_SEL = 4'd14; A = 8'h00; B = 8'h00;
    RST = 1'b1;
    tick();
    n_checks++; if (C_FLAG !== 1'b0) begin n_fail++; $display("FAIL reset_c: got %b expected 0", C_FLAG); end
    n_checks++; if (Z_FLAG !== 1'b0) begin n_fail++; $display("FAIL reset_z: got %b expected 0", Z_FLAG); end
    n_checks++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", BUSY); end
    RST = 1'b0; FLG_C_SET = 1'b1;
    tick();
    n_checks++; if (C_FLAG !== 1'b1) begin n_fail++; $display("FAIL set_c: got %b expected 1", C_FLAG); end
    RST = 1'b1;
    tick();
    n_checks++; if (C_FLAG !== 1'b0) begin n_fail++; $display("FAIL rst_over_set: got %b expected 0", C_FLAG); end
    idle_ctl();
  endtask

  task automatic test_arith();
    idle_ctl();
    A = 8'hFF; B = 8'h01; ALU_SEL = 4'd0; FLG_C_LD = 1'b1; FLG_Z_LD = 1'b1;
    #1;
    n_checks++; if (RESULT !== 8'h00) begin n_fail++; $display("FAIL add_result: got %h expected 00", RESULT); end
    tick();
    n_checks++; if (C_FLAG !== 1'b1) begin n_fail++; $display("FAIL add_c: got %b expected 1", C_FLAG); end
    n_checks++; if (Z_FLAG !== 1'b1) begin n_fail++; $display("FAIL add_z: got %b expected 1", Z_FLAG); end
    A = 8'h10; B = 8'h05; ALU_SEL = 4'd3;
    #1;
    n_checks++; if (RESULT !== 8'h0A) begin n_fail++; $display("FAIL subc_result: got %h expected 0a", RESULT); end
    tick();
    n_checks++; if (C_FLAG !== 1'b0) begin n_fail++; $display("FAIL subc_c: got %b expected 0", C_FLAG); end
    n_checks++; if (Z_FLAG !== 1'b0) begin n_fail++; $display("FAIL subc_z: got %b expected 0", Z_FLAG); end
    A = 8'h03; B = 8'h05; ALU_SEL = 4'd4;
    #1;
    n_checks++; if (RESULT !== 8'h03) begin n_fail++; $display("FAIL cmp_result: got %h expected 03", RESULT); end
    tick();
    n_checks++; if (C_FLAG !== 1'b1) begin n_fail++; $display("FAIL cmp_c: got %b expected 1", C_FLAG); end
    A = 8'h01; B = 8'h01; ALU_SEL = 4'd1;
    #1;
    n_checks++; if (RESULT !== 8'h03) begin n_fail++; $display("FAIL addc_result: got %h expected 03", RESULT); end
    A = 8'h20; B = 8'h10; ALU_SEL = 4'd2;
    #1;
    n_checks++; if (RESULT !== 8'h10) begin n_fail++; $display("FAIL sub_result: got %h expected 10", RESULT); end
    tick();
    n_checks++; if (C_FLAG !== 1'b0) begin n_fail++; $display("FAIL sub_c: got %b expected 0", C_FLAG); end
    idle_ctl();
  endtask

  task automatic test_shift();
    idle_ctl(); FLG_C_SET = 1'b1;
    tick();
    idle_ctl(); A = 8'h81; ALU_SEL = 4'd10;
    #1;
    n_checks++; if (RESULT !== 8'hC0) begin n_fail++; $display("FAIL lsr_result: got %h expected c0", RESULT); end
    ALU_SEL = 4'd13;
    #1;
    n_checks++; if (RESULT !== 8'hC0) begin n_fail++; $display("FAIL asr_result: got %h expected c0", RESULT); end
    A = 8'h40; ALU_SEL = 4'd9; FLG_C_LD = 1'b1;
    #1;
    n_checks++; if (RESULT !== 8'h81) begin n_fail++; $display("FAIL lsl_result: got %h expected 81", RESULT); end
    tick();
    n_checks++; if (C_FLAG !== 1'b0) begin n_fail++; $display("FAIL lsl_c: got %b expected 0", C_FLAG); end
    A = 8'h81; ALU_SEL = 4'd10;
    #1;
    n_checks++; if (RESULT !== 8'h40) begin n_fail++; $display("FAIL lsr_c0_result: got %h expected 40", RESULT); end
    tick();
    n_checks++; if (C_FLAG !== 1'b1) begin n_fail++; $display("FAIL lsr_c: got %b expected 1", C_FLAG); end
    FLG_C_CLR = 1'b1;
    tick();
    FLG_C_CLR = 1'b0; A = 8'h81; ALU_SEL = 4'd11;
    #1;
    n_checks++; if (RESULT !== 8'h03) begin n_fail++; $display("FAIL rol_result: got %h expected 03", RESULT); end
    tick();
    n_checks++; if (C_FLAG !== 1'b1) begin n_fail++; $display("FAIL rol_c: got %b expected 1", C_FLAG); end
    A = 8'h02; ALU_SEL = 4'd12;
    #1;
    n_checks++; if (RESULT !== 8'h01) begin n_fail++; $display("FAIL ror_result: got %h expected 01", RESULT); end
    tick();
    n_checks++; if (C_FLAG !== 1'b0) begin n_fail++; $display("FAIL ror_c: got %b expected 0", C_FLAG); end
    A = 8'h81; ALU_SEL = 4'd13;
    tick();
    n_checks++; if (C_FLAG !== 1'b1) begin n_fail++; $display("FAIL asr_c: got %b expected 1", C_FLAG); end
    idle_ctl();
  endtask

  task automatic test_logic();
    idle_ctl(); FLG_C_LD = 1'b1; FLG_Z_LD = 1'b1;
    A = 8'hF0; B = 8'h3C; ALU_SEL = 4'd5;
    #1;
    n_checks++; if (RESULT !== 8'h30) begin n_fail++; $display("FAIL and_result: got %h expected 30", RESULT); end
    tick();
    n_checks++; if (C_FLAG !== 1'b0) begin n_fail++; $display("FAIL and_c: got %b expected 0", C_FLAG); end
    n_checks++; if (Z_FLAG !== 1'b0) begin n_fail++; $display("FAIL and_z: got %b expected 0", Z_FLAG); end
    A = 8'hAA; B = 8'hAA; ALU_SEL = 4'd7;
    #1;
    n_checks++; if (RESULT !== 8'h00) begin n_fail++; $display("FAIL exor_result: got %h expected 00", RESULT); end
    tick();
    n_checks++; if (Z_FLAG !== 1'b1) begin n_fail++; $display("FAIL exor_z: got %b expected 1", Z_FLAG); end
    A = 8'hA0; B = 8'h05; ALU_SEL = 4'd6;
    #1;
    n_checks++; if (RESULT !== 8'hA5) begin n_fail++; $display("FAIL or_result: got %h expected a5", RESULT); end
    tick();
    n_checks++; if (Z_FLAG !== 1'b0) begin n_fail++; $display("FAIL or_z: got %b expected 0", Z_FLAG); end
    A = 8'h0F; B = 8'hF0; ALU_SEL = 4'd8;
    #1;
    n_checks++; if (RESULT !== 8'h0F) begin n_fail++; $display("FAIL test_result: got %h expected 0f", RESULT); end
    tick();
    n_checks++; if (Z_FLAG !== 1'b1) begin n_fail++; $display("FAIL test_z: got %b expected 1", Z_FLAG); end
    FLG_C_LD = 1'b0; FLG_Z_LD = 1'b0; FLG_C_SET = 1'b1;
    tick();
    FLG_C_SET = 1'b0; FLG_C_LD = 1'b1; FLG_Z_LD = 1'b1;
    A = 8'h00; B = 8'h5A; ALU_SEL = 4'd14;
    #1;
    n_checks++; if (RESULT !== 8'h5A) begin n_fail++; $display("FAIL mov_result: got %h expected 5a", RESULT); end
    tick();
    n_checks++; if (C_FLAG !== 1'b1) begin n_fail++; $display("FAIL mov_c: got %b expected 1", C_FLAG); end
    n_checks++; if (Z_FLAG !== 1'b0) begin n_fail++; $display("FAIL mov_z: got %b expected 0", Z_FLAG); end
    idle_ctl();
  endtask

  task automatic test_shadow();
    idle_ctl();
    FLG_C_SET = 1'b1; FLG_Z_LD = 1'b1; A = 8'h01; B = 8'h01; ALU_SEL = 4'd0;
    tick();
    idle_ctl(); FLG_SHAD_LD = 1'b1;
    tick();
    idle_ctl(); FLG_C_CLR = 1'b1; FLG_Z_LD = 1'b1; A = 8'h00; B = 8'h00;
    tick();
    n_checks++; if ({C_FLAG, Z_FLAG} !== 2'b01) begin n_fail++; $display("FAIL shad_modify: got %b expected 01", {C_FLAG, Z_FLAG}); end
    idle_ctl(); FLG_LD_SEL = 1'b1;
    tick();
    n_checks++; if ({C_FLAG, Z_FLAG} !== 2'b10) begin n_fail++; $display("FAIL shad_restore: got %b expected 10", {C_FLAG, Z_FLAG}); end
    idle_ctl(); FLG_C_CLR = 1'b1; FLG_Z_LD = 1'b1;
    tick();
    idle_ctl(); FLG_SHAD_LD = 1'b1; FLG_LD_SEL = 1'b1;
    tick();
    n_checks++; if ({C_FLAG, Z_FLAG} !== 2'b10) begin n_fail++; $display("FAIL shad_swap_flags: got %b expected 10", {C_FLAG, Z_FLAG}); end
    idle_ctl(); FLG_LD_SEL = 1'b1; FLG_C_SET = 1'b1;
    tick();
    n_checks++; if ({C_FLAG, Z_FLAG} !== 2'b01) begin n_fail++; $display("FAIL shad_swap_shadow: got %b expected 01", {C_FLAG, Z_FLAG}); end
    idle_ctl();
  endtask

  task automatic test_set_clr();
    idle_ctl(); FLG_C_SET = 1'b1;
    tick();
    FLG_C_CLR = 1'b1;
    tick();
    n_checks++; if (C_FLAG !== 1'b0) begin n_fail++; $display("FAIL set_clr_both: got %b expected 0", C_FLAG); end
    FLG_C_CLR = 1'b0; FLG_C_LD = 1'b1; A = 8'h00; B = 8'h00; ALU_SEL = 4'd0;
    tick();
    n_checks++; if (C_FLAG !== 1'b1) begin n_fail++; $display("FAIL set_over_load: got %b expected 1", C_FLAG); end
    idle_ctl();
  endtask

  task automatic test_op15();
`ifdef ALU_MUL_EN
    idle_ctl(); FLG_C_CLR = 1'b1; FLG_Z_LD = 1'b1; A = 8'h00; B = 8'h00; ALU_SEL = 4'd0;
    tick();
    idle_ctl(); A = 8'h12; B = 8'h34; ALU_SEL = 4'd14; START = 1'b1;
    tick();
    n_checks++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL mul_start_wrong_op: got %b expected 0", BUSY); end
    ALU_SEL = 4'd15;
    tick();
    START = 1'b0; A = 8'h00; B = 8'h00;
    for (int i = 0; i < 8; i++) begin
      n_checks++; if (BUSY !== 1'b1) begin n_fail++; $display("FAIL mul_busy_%0d: got %b expected 1", i, BUSY); end
      n_checks++; if (RESULT !== 8'h00) begin n_fail++; $display("FAIL mul_run_result_%0d: got %h expected 00", i, RESULT); end
      tick();
    end
    n_checks++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL mul_done_busy: got %b expected 0", BUSY); end
    n_checks++; if (RESULT !== 8'hA8) begin n_fail++; $display("FAIL mul_done_result: got %h expected a8", RESULT); end
    tick();
    n_checks++; if (RESULT !== 8'hA8) begin n_fail++; $display("FAIL mul_idle_result: got %h expected a8", RESULT); end
    n_checks++; if (C_FLAG !== 1'b1) begin n_fail++; $display("FAIL mul_c: got %b expected 1", C_FLAG); end
    n_checks++; if (Z_FLAG !== 1'b0) begin n_fail++; $display("FAIL mul_z: got %b expected 0", Z_FLAG); end
    A = 8'h02; B = 8'h03; START = 1'b1;
    tick();
    START = 1'b0;
    tick();
    tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    n_checks++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL mul_rst_busy: got %b expected 0", BUSY); end
    n_checks++; if (RESULT !== 8'h00) begin n_fail++; $display("FAIL mul_rst_result: got %h expected 00", RESULT); end
`else
    idle_ctl(); FLG_C_SET = 1'b1;
    tick();
    idle_ctl(); A = 8'h12; B = 8'h34; ALU_SEL = 4'd15; START = 1'b1;
    FLG_C_LD = 1'b1; FLG_Z_LD = 1'b1;
    #1;
    n_checks++; if (RESULT !== 8'h00) begin n_fail++; $display("FAIL op15_result: got %h expected 00", RESULT); end
    tick();
    n_checks++; if (C_FLAG !== 1'b0) begin n_fail++; $display("FAIL op15_c: got %b expected 0", C_FLAG); end
    n_checks++; if (Z_FLAG !== 1'b1) begin n_fail++; $display("FAIL op15_z: got %b expected 1", Z_FLAG); end
    n_checks++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL op15_busy: got %b expected 0", BUSY); end
`endif
    idle_ctl();
  endtask

  initial begin
    idle_ctl();
    ALU_SEL = 4'd0; A = 8'h00; B = 8'h00;
    test_reset();
    test_arith();
    test_shift();
    test_logic();
    test_shadow();
    test_set_clr();
    test_op15();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
